// File: rtl/stopwatch_control.sv
//------------------------------------------------------------------------------
// stopwatch_control
//
// Purpose:
//   Stopwatch control FSM and MM:SS time-keeping core. Time is held as four BCD
//   digits for the seven-segment display driver. The tick inputs are
//   clock-enable pulses on clk, not separate clocks.
//
// Parameters:
//   MAX_MIN      highest minute value, minutes wrap MAX_MIN -> 0 (1..99)
//
// Ports:
//   clk          in   1  system clock, all state on posedge
//   rst          in   1  synchronous, active-high reset
//   tick_1hz     in   1  1 Hz enable pulse, advances time in RUN
//   tick_2hz     in   1  2 Hz enable pulse, advances the selected field in ADJUST
//   pause_pulse  in   1  debounced pulse, toggles run/pause
//   clear_pulse  in   1  debounced pulse, zeroes the time
//   adj          in   1  level switch, 1 = adjust mode
//   sel          in   1  level switch, 0 = adjust seconds, 1 = adjust minutes
//   min_tens     out  4  BCD minutes tens digit
//   min_ones     out  4  BCD minutes ones digit
//   sec_tens     out  4  BCD seconds tens digit (0..5)
//   sec_ones     out  4  BCD seconds ones digit
//   running      out  1  high while in RUN
//   adj_active   out  1  high while in ADJUST
//------------------------------------------------------------------------------
module stopwatch_control #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_pulse,
    input  logic       clear_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       adj_active
);

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;

    logic [3:0] r_minTens;
    logic [3:0] r_minOnes;
    logic [3:0] r_secTens;
    logic [3:0] r_secOnes;

    logic [3:0] w_minTensNext;
    logic [3:0] w_minOnesNext;
    logic [3:0] w_secTensNext;
    logic [3:0] w_secOnesNext;

    // Incremented versions of each field; each field wraps on its own and
    // w_secWrap tells RUN whether the seconds wrap should carry into minutes.
    logic [3:0] w_secTensInc;
    logic [3:0] w_secOnesInc;
    logic [3:0] w_minTensInc;
    logic [3:0] w_minOnesInc;
    logic       w_secWrap;
    logic       w_minWrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PAUSED;
            r_minTens <= 4'd0;
            r_minOnes <= 4'd0;
            r_secTens <= 4'd0;
            r_secOnes <= 4'd0;
        end else begin
            r_state   <= w_stateNext;
            r_minTens <= w_minTensNext;
            r_minOnes <= w_minOnesNext;
            r_secTens <= w_secTensNext;
            r_secOnes <= w_secOnesNext;
        end
    end

    always_comb begin
        w_secWrap = (r_secTens == 4'd5) && (r_secOnes == 4'd9);
        w_minWrap = (r_minTens == MAX_MIN_TENS) && (r_minOnes == MAX_MIN_ONES);

        w_secTensInc = r_secTens;
        w_secOnesInc = r_secOnes + 4'd1;
        if (w_secWrap) begin
            w_secTensInc = 4'd0;
            w_secOnesInc = 4'd0;
        end else if (r_secOnes == 4'd9) begin
            w_secTensInc = r_secTens + 4'd1;
            w_secOnesInc = 4'd0;
        end

        w_minTensInc = r_minTens;
        w_minOnesInc = r_minOnes + 4'd1;
        if (w_minWrap) begin
            w_minTensInc = 4'd0;
            w_minOnesInc = 4'd0;
        end else if (r_minOnes == 4'd9) begin
            w_minTensInc = r_minTens + 4'd1;
            w_minOnesInc = 4'd0;
        end
    end

    // Priority: clear > adj > pause > ticks. Clear zeroes the time but holds
    // the current state, so a running stopwatch restarts from 00:00.
    always_comb begin
        w_stateNext   = r_state;
        w_minTensNext = r_minTens;
        w_minOnesNext = r_minOnes;
        w_secTensNext = r_secTens;
        w_secOnesNext = r_secOnes;

        if (clear_pulse) begin
            w_minTensNext = 4'd0;
            w_minOnesNext = 4'd0;
            w_secTensNext = 4'd0;
            w_secOnesNext = 4'd0;
        end else if (adj) begin
            w_stateNext = ADJUST;
            // Entering ADJUST takes one cycle; only an established ADJUST
            // state acts on tick_2hz.
            if ((r_state == ADJUST) && tick_2hz) begin
                if (sel) begin
                    w_minTensNext = w_minTensInc;
                    w_minOnesNext = w_minOnesInc;
                end else begin
                    w_secTensNext = w_secTensInc;
                    w_secOnesNext = w_secOnesInc;
                end
            end
        end else begin
            case (r_state)
                PAUSED: begin
                    if (pause_pulse) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    // A pause coinciding with a tick still takes the tick.
                    if (pause_pulse) begin
                        w_stateNext = PAUSED;
                    end
                    if (tick_1hz) begin
                        w_secTensNext = w_secTensInc;
                        w_secOnesNext = w_secOnesInc;
                        if (w_secWrap) begin
                            w_minTensNext = w_minTensInc;
                            w_minOnesNext = w_minOnesInc;
                        end
                    end
                end
                ADJUST: begin
                    // Leaving adjust always lands in PAUSED, never RUN.
                    w_stateNext = PAUSED;
                end
                default: begin
                    w_stateNext = PAUSED;
                end
            endcase
        end
    end

    assign min_tens   = r_minTens;
    assign min_ones   = r_minOnes;
    assign sec_tens   = r_secTens;
    assign sec_ones   = r_secOnes;
    assign running    = (r_state == RUN);
    assign adj_active = (r_state == ADJUST);

endmodule

// File: tb/tb_stopwatch_control.sv
//------------------------------------------------------------------------------
// tb_stopwatch_control
//
// Purpose:
//   Directed testbench for stopwatch_control. Each step drives one cycle of
//   inputs, then compares the displayed MM:SS (packed as four BCD nibbles)
//   and the status flags against hand-computed values.
//------------------------------------------------------------------------------
module tb_stopwatch_control;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_pulse;
    logic       clear_pulse;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       adj_active;

    logic [15:0] timeBcd;
    int          vectorCount;
    int          missCount;

    assign timeBcd = {min_tens, min_ones, sec_tens, sec_ones};

    stopwatch_control #(
        .MAX_MIN(59)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .pause_pulse(pause_pulse),
        .clear_pulse(clear_pulse),
        .adj        (adj),
        .sel        (sel),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .adj_active (adj_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of pulse inputs (adj/sel are levels set directly),
    // then drops the pulses 1 time unit after the edge so outputs are stable.
    task automatic applyStimulus(input logic pRst, input logic pTick1,
                                 input logic pTick2, input logic pPause,
                                 input logic pClear);
        rst         = pRst;
        tick_1hz    = pTick1;
        tick_2hz    = pTick2;
        pause_pulse = pPause;
        clear_pulse = pClear;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        pause_pulse = 1'b0;
        clear_pulse = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One tick_1hz pulse followed by an idle cycle, n times.
    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic adjustTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst         = 1'b1;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        pause_pulse = 1'b0;
        clear_pulse = 1'b0;
        adj         = 1'b0;
        sel         = 1'b0;

        // Reset for two cycles, start, count 61 seconds.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_time", timeBcd, 16'h0000);
        checkOutput("reset_running", {15'd0, running}, 16'd0);
        checkOutput("reset_adj", {15'd0, adj_active}, 16'd0);
        runTicks(2);
        checkOutput("paused_ignores_tick", timeBcd, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("start_running", {15'd0, running}, 16'd1);
        runTicks(61);
        checkOutput("t1_time", timeBcd, 16'h0101);
        checkOutput("t1_running", {15'd0, running}, 16'd1);

        // Preload 59:58 through ADJUST, then run through the wrap.
        adj = 1'b1;
        idle();
        checkOutput("adj_enter", {14'd0, adj_active, running}, 16'b10);
        sel = 1'b1;
        adjustTicks(58);
        sel = 1'b0;
        adjustTicks(57);
        checkOutput("t2_preload", timeBcd, 16'h5958);
        adj = 1'b0;
        idle();
        checkOutput("adj_exit_paused", {14'd0, adj_active, running}, 16'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_5959", timeBcd, 16'h5959);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_wrap", timeBcd, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_0001", timeBcd, 16'h0001);

        // Pause coinciding with a tick in RUN and in PAUSED.
        runTicks(9);
        checkOutput("t3_0010", timeBcd, 16'h0010);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_pause_tick_time", timeBcd, 16'h0011);
        checkOutput("t3_pause_tick_run", {15'd0, running}, 16'd0);
        runTicks(5);
        checkOutput("t3_paused_hold", timeBcd, 16'h0011);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("resume_tick_time", timeBcd, 16'h0011);
        checkOutput("resume_tick_run", {15'd0, running}, 16'd1);
        runTicks(44);
        checkOutput("t4_start", timeBcd, 16'h0055);

        // Adjust seconds with wrap (no carry), then minutes.
        adj = 1'b1;
        sel = 1'b0;
        idle();
        adjustTicks(7);
        checkOutput("t4_sec_wrap", timeBcd, 16'h0002);
        sel = 1'b1;
        adjustTicks(2);
        checkOutput("t4_min_adj", timeBcd, 16'h0202);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_pause_ignored", {14'd0, adj_active, running}, 16'b10);
        checkOutput("t4_tick1_ignored", timeBcd, 16'h0202);
        adj = 1'b0;
        idle();
        checkOutput("t4_exit_paused", {14'd0, adj_active, running}, 16'b00);

        // Clear coinciding with a tick in RUN at 12:34.
        adj = 1'b1;
        idle();
        sel = 1'b1;
        adjustTicks(10);
        sel = 1'b0;
        adjustTicks(32);
        adj = 1'b0;
        idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_start", {timeBcd[15:1], running}, {15'h091A, 1'b1});
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_clear_time", timeBcd, 16'h0000);
        checkOutput("t5_clear_run", {15'd0, running}, 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_after_clear", timeBcd, 16'h0001);

        // Reset together with pause, mid-RUN at 07:07.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        adj = 1'b1;
        idle();
        sel = 1'b1;
        adjustTicks(7);
        sel = 1'b0;
        adjustTicks(7);
        adj = 1'b0;
        idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_0707", timeBcd, 16'h0707);
        checkOutput("t6_running", {15'd0, running}, 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_rst_time", timeBcd, 16'h0000);
        checkOutput("t6_rst_flags", {14'd0, adj_active, running}, 16'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
